count_rate_sampler: RTL and testbench
=====================================

# count_rate_sampler

Downstream consumer of the free-running 16-bit event counter: it samples the counter's asynchronous output in the system clock domain at a fixed gate interval. It computes the number of events per gate (modular difference of successive samples) and hands each result to the video-control logic over a valid/ready handshake. Sticky flags report unstable samples and dropped results.

## Interface
- GATE_CYCLES, 50000, gate interval in clk cycles; legal range 16..2^24-1.
- STABLE_TRIES, 4, max SAMPLE cycles allowed to obtain a stable counter reading; legal range 1..GATE_CYCLES-8.

- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- cnt_in  in  16  counter value from the event counter; asynchronous to clk.
- out_ready  in  1  consumer accepts out_data when high with out_valid.
- err_clr  in  1  synchronous, 1-cycle; clears sample_err and overrun.
- out_data  out  16  events counted in the last gate, modulo 2^16.
- out_valid  out  1  out_data holds an unaccepted result.
- sample_err  out  1  sticky; a gate was skipped because cnt_in never settled.
- overrun  out  1  sticky; a result was dropped because out_valid was still high.

## Operation
- Input capture: three-stage register chain s1<=cnt_in, s2<=s1, s3<=s2 on every clk. A reading is stable when s2==s3.
- Gate timer: free-running counter 0..GATE_CYCLES-1 that wraps to 0. gate_tick is high in the cycle it equals GATE_CYCLES-1. It runs in every state.
- States:
  - IDLE: on gate_tick, go to SAMPLE and clear the try counter.
  - SAMPLE: if s2==s3, load cur<=s2 and go to PUBLISH. Otherwise increment tries. When tries reaches STABLE_TRIES, set sample_err and return to IDLE. No result is produced and prev is unchanged.
  - PUBLISH: compute delta=cur-prev as 16-bit wrap-around subtraction, load prev<=cur, and return to IDLE.
    - If primed==0 (first capture since reset), only set primed<=1; there is no output.
    - Else, if out_valid==0 or the current cycle is an accept, load out_data<=delta and out_valid<=1.
    - Else drop delta and set overrun. out_data is not modified.
- Handshake: a transfer occurs in a cycle where out_valid & out_ready. out_valid deasserts on the next edge unless PUBLISH reloads it in the same cycle.
- err_clr clears both sticky flags. If err_clr coincides with a new error event, the set wins.
- Reset (async, clr=0): state=IDLE, gate timer=0, s1..s3=0, prev=0, cur=0, primed=0, out_data=0, out_valid=0, sample_err=0, overrun=0. A mid-gate or mid-handshake reset discards everything. The first gate after release only primes.

## Timing
- Gate ticks every GATE_CYCLES cycles. The first tick is at cycle GATE_CYCLES-1 after reset release.
- The cnt_in change appears in s2 after 2 edges and in s3 after 3 edges.
- Latency with stable input, tick at cycle T:
  - SAMPLE at T+1.
  - PUBLISH at T+2.
  - out_valid high and out_data valid from T+3.
- A worst-case sample completes by T+1+STABLE_TRIES. The legal parameter range guarantees that the FSM is back in IDLE before the next gate_tick, so ticks are never missed.
- out_data and out_valid are registered outputs and do not depend combinationally on out_ready.

## Test plan
- Basic rate:
  - Stimulus: GATE_CYCLES=16; cnt_in steps 0->100 before the 2nd tick and 100->350 before the 3rd tick, with out_ready=1.
  - Response: no output after the 1st gate, then out_data=100 and then 250, each with out_valid high for exactly 1 cycle at tick+3.
- Wrap-around:
  - Stimulus: prev primed at 0xFFF0, next sample 0x0010.
  - Response: out_data=0x0020.
- Overrun:
  - Stimulus: out_ready=0 for three gates with counts 10, 20, 30.
  - Response: out_data stays 10 with out_valid=1; overrun=1 after the 2nd result.
  - Stimulus: err_clr.
  - Response: overrun=0.
- Unstable input:
  - Stimulus: STABLE_TRIES=4; cnt_in toggles between 5 and 6 every clk across a gate.
  - Response: sample_err=1, no out_valid, prev unchanged; the next stable gate reports the delta from the pre-error prev.
- Accept/publish collision:
  - Stimulus: out_valid=1, and out_ready is asserted in the PUBLISH cycle.
  - Response: new value loaded, out_valid stays high, overrun=0.
- Reset mid-operation:
  - Stimulus: clr pulse during SAMPLE with out_valid=1.
  - Response: all outputs go to 0 immediately; the next gate primes only, and the first result appears after the 2nd post-reset tick.

Source files
------------

// File: rtl/count_rate_sampler.sv
// Samples an asynchronous 16-bit event counter once per gate interval and
// publishes the per-gate event count over a valid/ready handshake.
module count_rate_sampler #(
  parameter int unsigned GATE_CYCLES  = 50000,
  parameter int unsigned STABLE_TRIES = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] cnt_in,
  input  logic        out_ready,
  input  logic        err_clr,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        sample_err,
  output logic        overrun
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned GATE_W = 24;
  localparam int unsigned TRY_W  = $clog2(STABLE_TRIES + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SAMPLE  = 2'd1;
  localparam logic [1:0] PUBLISH = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [TRY_W-1:0] tries, tries_nxt;
  logic [GATE_W-1:0] gate_cnt;
  logic             gate_tick;
  logic [CNT_W-1:0] s1, s2, s3;
  logic [CNT_W-1:0] cur, prev, delta;
  logic             primed;
  logic             stable;
  logic             ld_cur, publish, try_fail;
  logic             accept, pub_load, pub_drop;

  assign gate_tick = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
  assign stable    = (s2 == s3);
  assign delta     = cur - prev;
  assign accept    = out_valid & out_ready;
  assign pub_load  = publish & primed & (~out_valid | out_ready);
  assign pub_drop  = publish & primed & out_valid & ~out_ready;

  // Next-state and control strobes
  always_comb begin
    state_nxt = state;
    tries_nxt = tries;
    ld_cur    = 1'b0;
    publish   = 1'b0;
    try_fail  = 1'b0;
    case (state)
      IDLE: begin
        if (gate_tick) begin
          state_nxt = SAMPLE;
          tries_nxt = '0;
        end
      end
      SAMPLE: begin
        if (stable) begin
          ld_cur    = 1'b1;
          state_nxt = PUBLISH;
        end else if (tries == TRY_W'(STABLE_TRIES - 1)) begin
          try_fail  = 1'b1;
          state_nxt = IDLE;
        end else begin
          tries_nxt = tries + TRY_W'(1);
        end
      end
      PUBLISH: begin
        publish   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      tries <= '0;
    end else begin
      state <= state_nxt;
      tries <= tries_nxt;
    end
  end

  // Synchroniser, gate timer, datapath and registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      gate_cnt   <= '0;
      cur        <= '0;
      prev       <= '0;
      primed     <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      sample_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;
      s3 <= s2;
      gate_cnt <= gate_tick ? '0 : gate_cnt + GATE_W'(1);
      if (ld_cur) cur <= s2;
      if (publish) begin
        prev   <= cur;
        primed <= 1'b1;
      end
      if (pub_load) begin
        out_data  <= delta;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      // A new error event takes priority over a coincident clear
      if (try_fail)     sample_err <= 1'b1;
      else if (err_clr) sample_err <= 1'b0;
      if (pub_drop)     overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_count_rate_sampler.sv
// Randomised scoreboard bench for count_rate_sampler with a gate-level
// reference model of priming, deltas, drops and sticky flags.
module tb_count_rate_sampler;

  localparam int G     = 16;
  localparam int TRIES = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] cnt_in = '0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        sample_err;
  logic        overrun;

  count_rate_sampler #(.GATE_CYCLES(G), .STABLE_TRIES(TRIES)) dut (
    .clk       (clk),
    .clr       (clr),
    .cnt_in    (cnt_in),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sample_err(sample_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc;

  // Model state: one entry per gate, no cycle-level detail
  bit          m_primed, m_pending, m_err, m_ovr;
  logic [15:0] m_prev;
  int          gidx;
  bit          have_last, last_unst;
  logic [15:0] last_val;

  always @(posedge clk or negedge clr)
    if (!clr) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted transfer must match the head of the queue
  always @(negedge clk) begin
    #1;
    if (clr && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0d expected no transfer (cycle %0d)",
                 out_data, cyc);
      end else begin
        mon_e = q.pop_front();
        check("out_data", int'(out_data), int'(mon_e.data));
        if (mon_e.cyc >= 0) check("out_latency", cyc, mon_e.cyc);
      end
    end
  end

  // Apply the outcome of the previous gate's tick, whose PUBLISH falls in this gate
  task automatic model_tick(input bit rdy);
    exp_t e;
    if (last_unst) begin
      m_err = 1'b1;
    end else if (!m_primed) begin
      m_primed = 1'b1;
      m_prev   = last_val;
    end else begin
      e.data = last_val - m_prev;
      m_prev = last_val;
      if (m_pending && !rdy) begin
        m_ovr = 1'b1;
      end else begin
        e.cyc = rdy ? gidx * G + 2 : -1;
        q.push_back(e);
        m_pending = 1'b1;
      end
    end
  endtask

  task automatic run_gate(input logic [15:0] val, input bit unst, input bit rdy, input bit eclr);
    bit carry;
    carry = have_last && last_unst;
    if (have_last) model_tick(rdy);
    if (rdy) m_pending = 1'b0;
    if (eclr) begin
      m_err = 1'b0;
      m_ovr = 1'b0;
    end
    for (int n = 1; n <= G; n++) begin
      @(negedge clk);
      if (n == 1) out_ready = rdy;
      if (unst || (carry && n < 4)) cnt_in = (cnt_in == 16'd5) ? 16'd6 : 16'd5;
      else if (n == 4)              cnt_in = val;
      err_clr = (eclr && n == 8);
    end
    check("out_valid", int'(out_valid), int'(m_pending));
    if (m_pending && q.size() > 0) check("held_data", int'(out_data), int'(q[0].data));
    check("sample_err", int'(sample_err), int'(m_err));
    check("overrun", int'(overrun), int'(m_ovr));
    have_last = 1'b1;
    last_unst = unst;
    last_val  = val;
    gidx++;
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #2 clr = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_sample_err", int'(sample_err), 0);
    check("rst_overrun", int'(overrun), 0);
    q.delete();
    m_primed = 0; m_pending = 0; m_err = 0; m_ovr = 0; m_prev = '0;
    gidx = 0; have_last = 0; last_unst = 0; last_val = '0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    @(negedge clk);
    do_reset();

    // Basic rate: prime, then 100 and 250
    run_gate(16'd0, 0, 1, 0);
    run_gate(16'd100, 0, 1, 0);
    run_gate(16'd350, 0, 1, 0);
    run_gate(16'd350, 0, 1, 0);

    // Wrap-around: 0xFFF0 -> 0x0010
    run_gate(16'hFFF0, 0, 1, 0);
    run_gate(16'h0010, 0, 1, 0);

    // Overrun with consumer stalled, then clear, then collision on accept
    run_gate(16'h0010 + 16'd10, 0, 0, 0);
    run_gate(16'h0010 + 16'd30, 0, 0, 0);
    run_gate(16'h0010 + 16'd60, 0, 0, 0);
    run_gate(16'h0010 + 16'd60, 0, 0, 0);
    run_gate(16'h0010 + 16'd60, 0, 0, 1);
    run_gate(16'h0010 + 16'd75, 0, 1, 0);

    // Unstable sample, then recovery from the pre-error prev
    run_gate(16'd0, 1, 1, 0);
    run_gate(16'd200, 0, 1, 0);
    run_gate(16'd260, 0, 1, 1);
    run_gate(16'd260, 0, 1, 0);

    // Reset while sampling with a stalled result outstanding
    run_gate(16'd300, 0, 0, 0);
    run_gate(16'd320, 0, 0, 0);
    do_reset();
    run_gate(16'd1000, 0, 1, 0);
    run_gate(16'd1040, 0, 1, 0);
    run_gate(16'd1100, 0, 1, 0);

    // Randomised traffic
    v = 16'd1100;
    for (int i = 0; i < 60; i++) begin
      v = v + 16'($urandom_range(0, 65535));
      run_gate(v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0));
    end

    // Drain and confirm nothing is left outstanding
    run_gate(v, 0, 1, 0);
    run_gate(v, 0, 1, 0);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
